// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-port data memory responder with fixed wait-state latency.
// Define DMEM_ERR_CHECK_EN to fault illegal access codes and out-of-range addresses.
module dmem_responder #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 15,
  parameter int MemDepth   = 1024,
  parameter int WaitStates = 1
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_byte_en,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [DataWidth-1:0] rdata,
  output logic                 err
);

  localparam int IdxWidth = (MemDepth > 1) ? $clog2(MemDepth) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_next;
  logic [3:0]             cnt;
  logic                   lat_we;
  logic [2:0]             lat_be;
  logic [AddrWidth-1:0]   lat_addr;
  logic [DataWidth-1:0]   lat_wdata;
  logic [DataWidth-1:0]   mem [MemDepth];

  logic                   accept, enter_resp, fault;
  logic                   acc_we;
  logic [2:0]             acc_be;
  logic [AddrWidth-1:0]   acc_addr;
  logic [DataWidth-1:0]   acc_wdata;
  logic [IdxWidth-1:0]    idx;
  logic [DataWidth-1:0]   wmask, wbits, merged;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: if (req_valid) state_next = (WaitStates > 0) ? WAIT : RESP;
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept     = (state == IDLE) && req_valid;
  assign enter_resp = (state_next == RESP) && (state != RESP);

  // With zero wait states RESP is entered on the accept edge, before the latch is loaded.
  assign acc_we    = (state == IDLE) ? req_we      : lat_we;
  assign acc_be    = (state == IDLE) ? req_byte_en : lat_be;
  assign acc_addr  = (state == IDLE) ? req_addr    : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata   : lat_wdata;
  assign idx       = IdxWidth'(acc_addr % AddrWidth'(MemDepth));

`ifdef DMEM_ERR_CHECK_EN
  assign fault = (acc_be == 3'b111) || (acc_addr >= AddrWidth'(MemDepth));
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    wmask = '1;
    wbits = acc_wdata;
    case (acc_be)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        wmask = DataWidth'(8'hFF) << {acc_be[1:0], 3'b000};
        wbits = DataWidth'(acc_wdata[7:0]) << {acc_be[1:0], 3'b000};
      end
      3'b100: begin
        wmask = DataWidth'(16'hFFFF);
        wbits = DataWidth'(acc_wdata[15:0]);
      end
      3'b101: begin
        wmask = DataWidth'(16'hFFFF) << 16;
        wbits = DataWidth'(acc_wdata[15:0]) << 16;
      end
      default: ;
    endcase
    merged = (mem[idx] & ~wmask) | (wbits & wmask);
  end

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_be    <= 3'b000;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_we    <= req_we;
        lat_be    <= req_byte_en;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= (WaitStates > 0) ? 4'(WaitStates - 1) : 4'd0;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && !acc_we && !fault) rdata <= mem[idx];
    end
  end

  // Storage has no reset; a reset held across an edge must still block the write.
  always_ff @(posedge brq_clk) begin
    if (enter_resp && acc_we && !fault && !brq_rst) mem[idx] <= merged;
  end

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;

  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      err_q <= 1'b0;
    end else if (enter_resp) begin
      err_q <= fault;
    end else if (state == RESP) begin
      err_q <= 1'b0;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (WaitStates = 1).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_byte_en = 3'b000;
  logic [14:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        busy, resp_valid, err;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DataWidth(32), .AddrWidth(15), .MemDepth(1024), .WaitStates(1)
  ) dut (
    .brq_clk(clk),
    .brq_rst(rst),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_byte_en(req_byte_en),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .busy(busy),
    .resp_valid(resp_valid),
    .rdata(rdata),
    .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One request with latency checks: accept edge, WAIT, RESP, back to IDLE.
  task automatic do_req(input string tag, input logic we, input logic [2:0] code,
                        input logic [14:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e);
    req_valid = 1'b1; req_we = we; req_byte_en = code; req_addr = a; req_wdata = d;
    tick;
    req_valid = 1'b0;
    check1({tag, "/busy_wait"}, busy, 1'b1);
    check1({tag, "/resp_early"}, resp_valid, 1'b0);
    tick;
    check1({tag, "/resp"}, resp_valid, 1'b1);
    rd = rdata;
    e  = err;
    tick;
    check1({tag, "/resp_end"}, resp_valid, 1'b0);
    check1({tag, "/idle"}, busy, 1'b0);
  endtask

  logic [31:0] rd;
  logic        e;
  logic [5:0]  busy_pat, resp_pat;
  int          nresp;

  initial begin
    #12;
    check1("rst/busy", busy, 1'b0);
    check1("rst/resp_valid", resp_valid, 1'b0);
    check("rst/rdata", rdata, 32'h0);
    check1("rst/err", err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req("st5", 1'b1, 3'b110, 15'd5, 32'hDEADBEEF, rd, e);
    check1("st5/err", e, 1'b0);
    do_req("ld5", 1'b0, 3'b110, 15'd5, 32'h0, rd, e);
    check("ld5/rdata", rd, 32'hDEADBEEF);
    check1("ld5/err", e, 1'b0);

    do_req("st7w", 1'b1, 3'b110, 15'd7, 32'h11223344, rd, e);
    check("st7w/rdata_held", rd, 32'hDEADBEEF);
    do_req("st7b", 1'b1, 3'b010, 15'd7, 32'hFFFFFFAA, rd, e);
    do_req("ld7", 1'b0, 3'b110, 15'd7, 32'h0, rd, e);
    check("ld7/byte_merge", rd, 32'h11AA3344);

    do_req("st9w", 1'b1, 3'b110, 15'd9, 32'h00000000, rd, e);
    do_req("st9h", 1'b1, 3'b101, 15'd9, 32'h1234BEEF, rd, e);
    do_req("ld9a", 0, 3'b110, 15'd9, 32'h0, rd, e);
    check("ld9a/half_high", rd, 32'hBEEF0000);
    do_req("st9b0", 1'b1, 3'b000, 15'd9, 32'h0000005A, rd, e);
    do_req("ld9b", 0, 3'b110, 15'd9, 32'h0, rd, e);
    check("ld9b/byte0", rd, 32'hBEEF005A);
    do_req("st9l", 1'b1, 3'b100, 15'd9, 32'hFFFF1234, rd, e);
    do_req("ld9c", 0, 3'b110, 15'd9, 32'h0, rd, e);
    check("ld9c/half_low", rd, 32'hBEEF1234);

    // Held request for six edges: accepts at edges 0 and 3 only.
    busy_pat = 6'b011011;
    resp_pat = 6'b010010;
    nresp = 0;
    req_valid = 1'b1; req_we = 1'b0; req_byte_en = 3'b110; req_addr = 15'd5;
    for (int k = 0; k < 6; k++) begin
      tick;
      check1($sformatf("held/busy%0d", k), busy, busy_pat[k]);
      check1($sformatf("held/resp%0d", k), resp_valid, resp_pat[k]);
      if (resp_valid) nresp++;
    end
    req_valid = 1'b0;
    tick;
    check1("held/tail_resp", resp_valid, 1'b0);
    check("held/count", nresp, 2);
    check("held/rdata", rdata, 32'hDEADBEEF);

    // Reset while a store waits: no write, no response, storage retained.
    do_req("st3w", 1'b1, 3'b110, 15'd3, 32'h00000000, rd, e);
    req_valid = 1'b1; req_we = 1'b1; req_byte_en = 3'b110; req_addr = 15'd3; req_wdata = 32'h55;
    tick;
    req_valid = 1'b0;
    check1("mid/busy_wait", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check1("mid/busy", busy, 1'b0);
    check1("mid/resp", resp_valid, 1'b0);
    check("mid/rdata", rdata, 32'h0);
    check1("mid/err", err, 1'b0);
    tick;
    check1("mid/resp1", resp_valid, 1'b0);
    tick;
    check1("mid/resp2", resp_valid, 1'b0);
    rst = 1'b0;
    do_req("ld3", 1'b0, 3'b110, 15'd3, 32'h0, rd, e);
    check("ld3/no_write", rd, 32'h0);
    do_req("ld5r", 1'b0, 3'b110, 15'd5, 32'h0, rd, e);
    check("ld5r/retained", rd, 32'hDEADBEEF);

`ifdef DMEM_ERR_CHECK_EN
    do_req("f111", 1'b1, 3'b111, 15'd7, 32'h12345678, rd, e);
    check1("f111/err", e, 1'b1);
    do_req("ld7f", 1'b0, 3'b110, 15'd7, 32'h0, rd, e);
    check("ld7f/unchanged", rd, 32'h11AA3344);
    check1("ld7f/err", e, 1'b0);
    do_req("st0", 1'b1, 3'b110, 15'd0, 32'hCAFEF00D, rd, e);
    do_req("fadr", 1'b1, 3'b110, 15'd1024, 32'h0BADBEEF, rd, e);
    check1("fadr/err", e, 1'b1);
    do_req("ld0f", 1'b0, 3'b110, 15'd0, 32'h0, rd, e);
    check("ld0f/unchanged", rd, 32'hCAFEF00D);
    do_req("fld", 1'b0, 3'b111, 15'd5, 32'h0, rd, e);
    check1("fld/err", e, 1'b1);
    check("fld/rdata_held", rd, 32'hCAFEF00D);
`else
    do_req("w111", 1'b1, 3'b111, 15'd7, 32'h12345678, rd, e);
    check1("w111/err", e, 1'b0);
    do_req("ld7w", 1'b0, 3'b110, 15'd7, 32'h0, rd, e);
    check("ld7w/word", rd, 32'h12345678);
    do_req("wrap", 1'b1, 3'b110, 15'd1024, 32'h0BADBEEF, rd, e);
    check1("wrap/err", e, 1'b0);
    do_req("ld0w", 1'b0, 3'b110, 15'd0, 32'h0, rd, e);
    check("ld0w/wrapped", rd, 32'h0BADBEEF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
